// File: rtl/crc_serial_engine_if.sv
// Bus between the frame control logic and the serial CRC engine.
// The master drives the serial pair and the frame controls; the slave (the engine) returns the CRC status.
interface crc_serial_engine_if #(
    parameter int unsigned CRC_WIDTH = 4
);
    logic                 serialClk;
    logic                 serialData;
    logic                 start;
    logic                 enable;
    logic                 mode;
    logic [CRC_WIDTH-1:0] crc;
    logic                 crcBit;
    logic                 busy;
    logic                 done;
    logic                 crcError;

    modport master (
        output serialClk, serialData, start, enable, mode,
        input  crc, crcBit, busy, done, crcError
    );

    modport slave (
        input  serialClk, serialData, start, enable, mode,
        output crc, crcBit, busy, done, crcError
    );
endinterface

// File: rtl/crc_serial_engine.sv
// Serial CRC generator/checker: synchronises an external serialClk/serialData pair into masterClk
// and runs an LFSR over the payload, then either shifts the remainder out or checks it.
module crc_serial_engine #(
    parameter int unsigned          CRC_WIDTH   = 4,
    parameter logic [CRC_WIDTH-1:0] POLY        = 4'b0011,
    parameter logic [CRC_WIDTH-1:0] INIT        = '0,
    parameter int unsigned          SYNC_STAGES = 2
) (
    input logic                masterClk,
    input logic                reset,
    crc_serial_engine_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(CRC_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        SHIFT,
        CHECK
    } state_t;

    logic [SYNC_STAGES-1:0] clkSync_q;
    logic [SYNC_STAGES-1:0] dataSync_q;
    logic                   prevSyncClk_q;

    state_t               state_q;
    logic [CRC_WIDTH-1:0] crc_q;
    logic [CNT_W-1:0]     bitCnt_q;
    logic                 done_q;
    logic                 crcError_q;
    logic                 modeLatched_q;
    logic                 busy_q;

    logic                 syncClk;
    logic                 dataBit;
    logic                 bitEdge;
    logic                 mismatch;
    logic                 lastBit;
    logic [CRC_WIDTH-1:0] crcLfsr_d;
    logic [CRC_WIDTH-1:0] crcShift_d;
    logic [CNT_W-1:0]     bitCnt_d;

    always_ff @(posedge masterClk or negedge reset) begin
        if (!reset) begin
            clkSync_q     <= '0;
            dataSync_q    <= '0;
            prevSyncClk_q <= 1'b0;
        end else begin
            clkSync_q     <= {clkSync_q[SYNC_STAGES-2:0], bus.serialClk};
            dataSync_q    <= {dataSync_q[SYNC_STAGES-2:0], bus.serialData};
            prevSyncClk_q <= clkSync_q[SYNC_STAGES-1];
        end
    end

    always_comb begin
        syncClk    = clkSync_q[SYNC_STAGES-1];
        dataBit    = dataSync_q[SYNC_STAGES-1];
        bitEdge    = syncClk & ~prevSyncClk_q;
        mismatch   = dataBit ^ crc_q[CRC_WIDTH-1];
        crcShift_d = {crc_q[CRC_WIDTH-2:0], 1'b0};
        crcLfsr_d  = crcShift_d ^ (mismatch ? POLY : '0);
        bitCnt_d   = bitCnt_q + 1'b1;
        lastBit    = (bitCnt_q == CNT_W'(CRC_WIDTH - 1));
    end

    // start outranks a coincident bitEdge, so that edge is silently dropped.
    always_ff @(posedge masterClk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            crc_q         <= INIT;
            bitCnt_q      <= '0;
            done_q        <= 1'b0;
            crcError_q    <= 1'b0;
            modeLatched_q <= 1'b0;
            busy_q        <= 1'b0;
        end else if (bus.start) begin
            state_q    <= CALC;
            crc_q      <= INIT;
            bitCnt_q   <= '0;
            done_q     <= 1'b0;
            crcError_q <= 1'b0;
            busy_q     <= 1'b1;
        end else if (bitEdge) begin
            case (state_q)
                IDLE: ;
                CALC: begin
                    if (bus.enable) begin
                        crc_q <= crcLfsr_d;
                    end else begin
                        // The edge that ends the payload is already the first CRC-phase bit.
                        modeLatched_q <= bus.mode;
                        if (bus.mode && mismatch) begin
                            crcError_q <= 1'b1;
                        end
                        crc_q    <= crcShift_d;
                        bitCnt_q <= CNT_W'(1);
                        state_q  <= bus.mode ? CHECK : SHIFT;
                    end
                end
                SHIFT, CHECK: begin
                    if (modeLatched_q && mismatch) begin
                        crcError_q <= 1'b1;
                    end
                    bitCnt_q <= bitCnt_d;
                    if (lastBit) begin
                        crc_q   <= '0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        crc_q <= crcShift_d;
                    end
                end
            endcase
        end
    end

    assign bus.crc      = crc_q;
    assign bus.crcBit   = crc_q[CRC_WIDTH-1];
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.crcError = crcError_q;
endmodule

// File: tb/tb_crc_serial_engine.sv
// Randomised bench for crc_serial_engine: a 4-bit (x^4+x+1) and an 8-bit (0x07) instance
// checked against a polynomial long-division model of the remainder.
module tb_crc_serial_engine;
    logic masterClk = 1'b0;
    logic reset     = 1'b0;
    int   nCmp      = 0;
    int   nBad      = 0;

    always #5 masterClk = ~masterClk;

    crc_serial_engine_if #(.CRC_WIDTH(4)) if4 ();
    crc_serial_engine_if #(.CRC_WIDTH(8)) if8 ();

    crc_serial_engine #(
        .CRC_WIDTH(4), .POLY(4'b0011), .INIT(4'h0), .SYNC_STAGES(2)
    ) dut4 (
        .masterClk(masterClk), .reset(reset), .bus(if4.slave)
    );

    crc_serial_engine #(
        .CRC_WIDTH(8), .POLY(8'h07), .INIT(8'h00), .SYNC_STAGES(3)
    ) dut8 (
        .masterClk(masterClk), .reset(reset), .bus(if8.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCmp++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Remainder of M(x)*x^w divided by G(x), by long division (INIT = 0).
    function automatic logic [31:0] refCrc(input logic [31:0] msg, input int len,
                                           input int w, input logic [31:0] poly);
        longint unsigned v;
        longint unsigned g;
        v = longint'(msg) << w;
        g = (64'd1 << w) | longint'(poly);
        for (int i = len + w - 1; i >= w; i--) begin
            if (v[i]) v = v ^ (g << (i - w));
        end
        return 32'(v & ((64'd1 << w) - 64'd1));
    endfunction

    function automatic logic [31:0] curCrc(input int which);
        return (which == 0) ? 32'(if4.crc) : 32'(if8.crc);
    endfunction
    function automatic logic [31:0] curBit(input int which);
        return (which == 0) ? 32'(if4.crcBit) : 32'(if8.crcBit);
    endfunction
    function automatic logic [31:0] curDone(input int which);
        return (which == 0) ? 32'(if4.done) : 32'(if8.done);
    endfunction
    function automatic logic [31:0] curErr(input int which);
        return (which == 0) ? 32'(if4.crcError) : 32'(if8.crcError);
    endfunction
    function automatic logic [31:0] curBusy(input int which);
        return (which == 0) ? 32'(if4.busy) : 32'(if8.busy);
    endfunction

    task automatic tick();
        @(posedge masterClk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic setSer(input int which, input logic sc, input logic sd, input logic en);
        if (which == 0) begin
            if4.serialClk = sc; if4.serialData = sd; if4.enable = en;
        end else begin
            if8.serialClk = sc; if8.serialData = sd; if8.enable = en;
        end
    endtask

    task automatic setMode(input int which, input logic m);
        if (which == 0) if4.mode = m;
        else            if8.mode = m;
    endtask

    task automatic setStart(input int which, input logic s);
        if (which == 0) if4.start = s;
        else            if8.start = s;
    endtask

    task automatic pulseStart(input int which);
        setStart(which, 1'b1);
        tick();
        setStart(which, 1'b0);
    endtask

    // One serial bit with the minimum legal high and low phase (SYNC_STAGES+1 cycles).
    task automatic sendBit(input int which, input logic b, input logic en);
        int ph;
        ph = (which == 0) ? 3 : 4;
        setSer(which, 1'b1, b, en);
        ticks(ph);
        setSer(which, 1'b0, b, en);
        ticks(ph);
    endtask

    task automatic sendPayload(input int which, input logic [31:0] msg, input int len);
        for (int i = len - 1; i >= 0; i--) begin
            setMode(which, 1'($urandom));
            sendBit(which, msg[i], 1'b1);
        end
    endtask

    task automatic crcPhase(input int which, input logic chkMode,
                            input logic [31:0] corrupt, input logic [31:0] refc);
        int   w;
        logic expErr;
        logic e;
        logic d;
        w      = (which == 0) ? 4 : 8;
        expErr = 1'b0;
        for (int k = 0; k < w; k++) begin
            e = refc[w - 1 - k];
            if (!chkMode) chk("crcBit", curBit(which), 32'(e));
            d = chkMode ? (e ^ corrupt[k]) : 1'($urandom);
            setMode(which, (k == 0) ? chkMode : 1'($urandom));
            sendBit(which, d, (k == 0) ? 1'b0 : 1'($urandom));
            if (chkMode && corrupt[k]) expErr = 1'b1;
            chk("crcError", curErr(which), 32'(expErr));
            chk("done", curDone(which), 32'(k == w - 1));
        end
        chk("busy_end", curBusy(which), 32'd0);
        chk("crc_end", curCrc(which), 32'd0);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int          which;
        int          len;
        int          w;
        logic [31:0] msg;
        logic [31:0] poly;
        logic [31:0] rc;
        logic [31:0] corrupt;
        logic        md;

        setSer(0, 1'b0, 1'b0, 1'b0); setMode(0, 1'b0); setStart(0, 1'b0);
        setSer(1, 1'b0, 1'b0, 1'b0); setMode(1, 1'b0); setStart(1, 1'b0);
        ticks(3);
        chk("rst_crc", curCrc(0), 32'd0);
        chk("rst_busy", curBusy(0), 32'd0);
        chk("rst_done", curDone(0), 32'd0);
        chk("rst_err", curErr(0), 32'd0);
        reset = 1'b1;
        ticks(2);

        // Generate: payload 1000 -> 1011, shifted out 1,0,1,1.
        pulseStart(0);
        chk("gen_busy", curBusy(0), 32'd1);
        sendPayload(0, 32'h8, 4);
        chk("gen_crc", curCrc(0), 32'hB);
        crcPhase(0, 1'b0, 32'd0, 32'hB);

        // Check pass, then check fail on third CRC bit; error sticky until next start.
        pulseStart(0);
        sendPayload(0, 32'h8, 4);
        crcPhase(0, 1'b1, 32'd0, 32'hB);
        pulseStart(0);
        sendPayload(0, 32'h8, 4);
        crcPhase(0, 1'b1, 32'h4, 32'hB);
        ticks(4);
        chk("err_sticky", curErr(0), 32'd1);
        pulseStart(0);
        chk("err_clr", curErr(0), 32'd0);
        chk("done_clr", curDone(0), 32'd0);

        // Restart mid-payload, then start coincident with a bitEdge.
        sendPayload(0, 32'h3, 2);
        chk("pre_restart", curCrc(0), refCrc(32'h3, 2, 4, 32'h3));
        pulseStart(0);
        chk("restart_crc", curCrc(0), 32'd0);
        setSer(0, 1'b1, 1'b1, 1'b1);
        ticks(2);
        setStart(0, 1'b1);
        tick();
        setStart(0, 1'b0);
        chk("collide_crc", curCrc(0), 32'd0);
        setSer(0, 1'b0, 1'b1, 1'b1);
        ticks(3);
        sendPayload(0, 32'h8, 4);
        chk("collide_pay", curCrc(0), 32'hB);
        crcPhase(0, 1'b0, 32'd0, 32'hB);

        // Async reset mid-SHIFT after two CRC bits.
        pulseStart(0);
        sendPayload(0, 32'h8, 4);
        setMode(0, 1'b0);
        sendBit(0, 1'b0, 1'b0);
        sendBit(0, 1'b0, 1'b0);
        chk("shift_busy", curBusy(0), 32'd1);
        chk("shift_crc", curCrc(0), 32'hC);
        #3 reset = 1'b0;
        #1;
        chk("arst_crc", curCrc(0), 32'd0);
        chk("arst_busy", curBusy(0), 32'd0);
        chk("arst_done", curDone(0), 32'd0);
        chk("arst_bit", curBit(0), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        sendBit(0, 1'b1, 1'b1);
        sendBit(0, 1'b1, 1'b1);
        chk("idle_crc", curCrc(0), 32'd0);
        chk("idle_busy", curBusy(0), 32'd0);

        // Capture latency is SYNC_STAGES+1 cycles on both instances.
        for (int wh = 0; wh < 2; wh++) begin
            pulseStart(wh);
            setSer(wh, 1'b1, 1'b1, 1'b1);
            for (int c = 1; c <= wh + 3; c++) begin
                tick();
                chk("latency", curCrc(wh), (c == wh + 3) ? ((wh == 0) ? 32'h3 : 32'h7) : 32'd0);
            end
            setSer(wh, 1'b0, 1'b1, 1'b1);
            ticks(wh + 3);
        end

        // 8-bit instance: payload 0x31 -> 0x97.
        pulseStart(1);
        sendPayload(1, 32'h31, 8);
        chk("crc8_31", curCrc(1), 32'h97);
        crcPhase(1, 1'b0, 32'd0, 32'h97);

        // Random frames, including empty payloads and corrupted check-mode CRCs.
        for (int n = 0; n < 40; n++) begin
            which = (n % 4 == 3) ? 1 : 0;
            w     = (which == 0) ? 4 : 8;
            poly  = (which == 0) ? 32'h3 : 32'h7;
            len   = int'($urandom_range(0, 12));
            msg   = $urandom & ((32'd1 << len) - 32'd1);
            md    = 1'($urandom);
            corrupt = 32'd0;
            if (md && ($urandom_range(0, 2) == 0))
                corrupt = ($urandom_range(1, (1 << w) - 1));
            rc = refCrc(msg, len, w, poly);
            pulseStart(which);
            chk("rnd_start", curCrc(which), 32'd0);
            sendPayload(which, msg, len);
            chk("rnd_crc", curCrc(which), rc);
            crcPhase(which, md, corrupt, rc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
